// File: rtl/cache_fill_ctrl.sv
// Miss-fill controller: on a miss, stalls the pipe and streams one cache block from pipelined memory.
// Optional CRITICAL_WORD_FIRST_EN starts issue/write order at the missing word and wraps.
module cache_fill_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  localparam int OFF_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write_data_array,
  output logic [OFF_W-1:0]  data_wr_word,
  output logic [DATA_W-1:0] data_wr_data,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] fill_base
);

  localparam int BYTE_SH = $clog2(DATA_W/8);
  localparam int BLK_SH  = OFF_W + BYTE_SH;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << BLK_SH) - ADDR_W'(1));

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state, state_nxt;
  logic [OFF_W:0]   issue_cnt;
  logic [OFF_W-1:0] recv_cnt;
  logic [OFF_W-1:0] issue_word, recv_word;
  logic             accept;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0] miss_off;
  // Offsets wrap inside the block by construction of the OFF_W-wide sum.
  assign issue_word = issue_cnt[OFF_W-1:0] + miss_off;
  assign recv_word  = recv_cnt + miss_off;
`else
  assign issue_word = issue_cnt[OFF_W-1:0];
  assign recv_word  = recv_cnt;
`endif

  always_comb begin
    state_nxt        = state;
    accept           = 1'b0;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    data_wr_word     = '0;
    data_wr_data     = '0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        // Reset holds state in IDLE, so gating here keeps every output low during rst.
        if (miss_detected && !rst) begin
          fsm_busy  = 1'b1;
          accept    = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_cnt[OFF_W]) begin
          mem_en   = 1'b1;
          // Base is block-aligned, so OR is the carry-free add.
          mem_addr = fill_base | (ADDR_W'(issue_word) << BYTE_SH);
        end
        if (mem_data_valid) begin
          write_data_array = 1'b1;
          data_wr_word     = recv_word;
          data_wr_data     = mem_data;
          if (recv_cnt == OFF_W'(BLOCK_WORDS-1)) begin
            write_tag_array = 1'b1;
            state_nxt       = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      fill_base <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      miss_off  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        fill_base <= miss_addr & BLK_MASK;
        issue_cnt <= '0;
        recv_cnt  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
        miss_off  <= OFF_W'(miss_addr >> BYTE_SH);
`endif
      end else if (write_tag_array) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (mem_en)           issue_cnt <= issue_cnt + (OFF_W+1)'(1);
        if (write_data_array) recv_cnt  <= recv_cnt + OFF_W'(1);
      end
    end
  end

endmodule
